// File: rtl/vec_execute_unit_if.sv
// Decode/execute operand bus and writeback beat for the vector execute stage.
// The master side drives operands and receives the writeback; the slave side is the unit.
interface vec_execute_unit_if;
  logic         in_valid;
  logic [4:0]   opcode;
  logic [31:0]  reg1_data;
  logic [31:0]  reg2_data;
  logic [7:0]   immediate;
  logic [127:0] vec1_data;
  logic [127:0] vec2_data;
  logic [2:0]   wb_register;

  logic         stall;
  logic         wb_valid;
  logic         wb_is_vec;
  logic [2:0]   wb_reg;
  logic [127:0] wb_data;
  logic         illegal_op;

  modport master (
    output in_valid, opcode, reg1_data, reg2_data, immediate, vec1_data, vec2_data, wb_register,
    input  stall, wb_valid, wb_is_vec, wb_reg, wb_data, illegal_op
  );

  modport slave (
    input  in_valid, opcode, reg1_data, reg2_data, immediate, vec1_data, vec2_data, wb_register,
    output stall, wb_valid, wb_is_vec, wb_reg, wb_data, illegal_op
  );
endinterface

// File: rtl/vec_execute_unit.sv
// Vector CPU execute stage: lane-wise 8-bit vector ops, 32-bit scalar add and a
// multi-cycle lane-group VMUL that stalls the decode/execute register while busy.
module vec_execute_unit #(
  parameter int unsigned LANE_W            = 8,
  parameter int unsigned MUL_LANES_PER_CYC = 4
) (
  input logic               clk,
  input logic               rst_n,
  vec_execute_unit_if.slave bus
);
  localparam int unsigned VecW   = 128;
  localparam int unsigned Lanes  = VecW / LANE_W;
  localparam int unsigned Groups = Lanes / MUL_LANES_PER_CYC;
  localparam int unsigned CntW   = (Groups > 1) ? $clog2(Groups) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Groups - 1);

  typedef enum logic {StIdle, StMul} state_e;

  typedef enum logic [4:0] {
    OpNop   = 5'h00,
    OpVadd  = 5'h01,
    OpVsub  = 5'h02,
    OpVxor  = 5'h03,
    OpVaddi = 5'h04,
    OpSadd  = 5'h05,
    OpVmul  = 5'h06,
    OpVshl  = 5'h07
  } op_e;

  state_e            r_state, w_state_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d;
  logic [VecW-1:0]   r_v1, w_v1_d;
  logic [VecW-1:0]   r_v2, w_v2_d;
  logic [VecW-1:0]   r_mul_res, w_mul_res_d;
  logic [2:0]        r_mul_reg, w_mul_reg_d;

  logic              r_wb_valid, w_wb_valid_d;
  logic              r_wb_is_vec, w_wb_is_vec_d;
  logic [2:0]        r_wb_reg, w_wb_reg_d;
  logic [VecW-1:0]   r_wb_data, w_wb_data_d;
  logic              r_illegal, w_illegal_d;

  logic [VecW-1:0]   w_vadd, w_vsub, w_vaddi, w_vshl, w_alu, w_mul_next;
  logic [31:0]       w_sadd;

  // Single-cycle datapath straight off the operand bus; no carries cross lane boundaries.
  always_comb begin
    w_vadd  = '0;
    w_vsub  = '0;
    w_vaddi = '0;
    w_vshl  = '0;
    for (int i = 0; i < int'(Lanes); i++) begin
      w_vadd[i*LANE_W +: LANE_W]  = bus.vec1_data[i*LANE_W +: LANE_W]
                                  + bus.vec2_data[i*LANE_W +: LANE_W];
      w_vsub[i*LANE_W +: LANE_W]  = bus.vec1_data[i*LANE_W +: LANE_W]
                                  - bus.vec2_data[i*LANE_W +: LANE_W];
      w_vaddi[i*LANE_W +: LANE_W] = bus.vec1_data[i*LANE_W +: LANE_W] + LANE_W'(bus.immediate);
      w_vshl[i*LANE_W +: LANE_W]  = bus.vec1_data[i*LANE_W +: LANE_W] << bus.immediate[2:0];
    end
    w_sadd = bus.reg1_data + bus.reg2_data;
  end

  always_comb begin
    w_alu = '0;
    case (bus.opcode)
      OpVadd:  w_alu = w_vadd;
      OpVsub:  w_alu = w_vsub;
      OpVxor:  w_alu = bus.vec1_data ^ bus.vec2_data;
      OpVaddi: w_alu = w_vaddi;
      OpSadd:  w_alu = {{(VecW-32){1'b0}}, w_sadd};
      OpVshl:  w_alu = w_vshl;
      default: w_alu = '0;
    endcase
  end

  // One lane group of the latched VMUL operands per cycle, selected by r_cnt.
  always_comb begin
    w_mul_next = r_mul_res;
    for (int g = 0; g < int'(MUL_LANES_PER_CYC); g++) begin
      w_mul_next[(32'(r_cnt) * MUL_LANES_PER_CYC + 32'(g)) * LANE_W +: LANE_W] =
          r_v1[(32'(r_cnt) * MUL_LANES_PER_CYC + 32'(g)) * LANE_W +: LANE_W] *
          r_v2[(32'(r_cnt) * MUL_LANES_PER_CYC + 32'(g)) * LANE_W +: LANE_W];
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_v1_d        = r_v1;
    w_v2_d        = r_v2;
    w_mul_res_d   = r_mul_res;
    w_mul_reg_d   = r_mul_reg;
    w_wb_valid_d  = 1'b0;
    w_wb_is_vec_d = r_wb_is_vec;
    w_wb_reg_d    = r_wb_reg;
    w_wb_data_d   = r_wb_data;
    w_illegal_d   = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (bus.in_valid) begin
          case (bus.opcode)
            OpNop: ;
            OpVmul: begin
              w_v1_d      = bus.vec1_data;
              w_v2_d      = bus.vec2_data;
              w_mul_reg_d = bus.wb_register;
              w_mul_res_d = '0;
              w_cnt_d     = '0;
              w_state_d   = StMul;
            end
            OpVadd, OpVsub, OpVxor, OpVaddi, OpSadd, OpVshl: begin
              w_wb_valid_d  = 1'b1;
              w_wb_reg_d    = bus.wb_register;
              w_wb_is_vec_d = (bus.opcode != OpSadd);
              w_wb_data_d   = w_alu;
            end
            default: w_illegal_d = 1'b1;
          endcase
        end
      end
      StMul: begin
        w_mul_res_d = w_mul_next;
        w_cnt_d     = r_cnt + CntW'(1);
        if (r_cnt == LastCnt) begin
          w_state_d     = StIdle;
          w_wb_valid_d  = 1'b1;
          w_wb_reg_d    = r_mul_reg;
          w_wb_is_vec_d = 1'b1;
          w_wb_data_d   = w_mul_next;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_v1        <= '0;
      r_v2        <= '0;
      r_mul_res   <= '0;
      r_mul_reg   <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_is_vec <= 1'b0;
      r_wb_reg    <= '0;
      r_wb_data   <= '0;
      r_illegal   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_v1        <= w_v1_d;
      r_v2        <= w_v2_d;
      r_mul_res   <= w_mul_res_d;
      r_mul_reg   <= w_mul_reg_d;
      r_wb_valid  <= w_wb_valid_d;
      r_wb_is_vec <= w_wb_is_vec_d;
      r_wb_reg    <= w_wb_reg_d;
      r_wb_data   <= w_wb_data_d;
      r_illegal   <= w_illegal_d;
    end
  end

  assign bus.stall      = (r_state == StMul);
  assign bus.wb_valid   = r_wb_valid;
  assign bus.wb_is_vec  = r_wb_is_vec;
  assign bus.wb_reg     = r_wb_reg;
  assign bus.wb_data    = r_wb_data;
  assign bus.illegal_op = r_illegal;
endmodule

// File: tb/tb_vec_execute_unit.sv
// Self-checking bench for vec_execute_unit: directed vector table, VMUL/reset corner
// sequences, and randomized ops against a lane-array arithmetic reference model.
module tb_vec_execute_unit;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  vec_execute_unit_if bus ();

  vec_execute_unit #(
    .LANE_W            (8),
    .MUL_LANES_PER_CYC (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  typedef struct {
    logic [4:0]   op;
    logic [31:0]  r1;
    logic [31:0]  r2;
    logic [7:0]   imm;
    logic [127:0] v1;
    logic [127:0] v2;
    logic [2:0]   wbr;
    logic         exp_valid;
    logic         exp_vec;
    logic         exp_ill;
    logic [127:0] exp_data;
  } vec_t;

  vec_t tbl[8];

  function automatic logic [127:0] splat(input logic [7:0] b);
    return {16{b}};
  endfunction

  // Reference: unpack bytes, do integer arithmetic, reduce mod 256 (mod 2^32 for SADD).
  function automatic logic [127:0] ref_model(input logic [4:0] op, input logic [31:0] r1,
                                             input logic [31:0] r2, input logic [7:0] imm,
                                             input logic [127:0] v1, input logic [127:0] v2);
    logic [127:0] res;
    int a, b, x;
    res = '0;
    if (op == 5'h05) return {96'b0, r1 + r2};
    for (int i = 0; i < 16; i++) begin
      a = int'(v1[8*i +: 8]);
      b = int'(v2[8*i +: 8]);
      case (op)
        5'h01:   x = a + b;
        5'h02:   x = a - b + 256;
        5'h03:   x = a ^ b;
        5'h04:   x = a + int'(imm);
        5'h06:   x = a * b;
        5'h07:   x = a << imm[2:0];
        default: x = 0;
      endcase
      res[8*i +: 8] = 8'(x % 256);
    end
    return res;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [7:0] imm, input logic [127:0] v1,
                       input logic [127:0] v2, input logic [2:0] wbr);
    bus.in_valid    = v;
    bus.opcode      = op;
    bus.reg1_data   = r1;
    bus.reg2_data   = r2;
    bus.immediate   = imm;
    bus.vec1_data   = v1;
    bus.vec2_data   = v2;
    bus.wb_register = wbr;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, bus.stall, 0);
    check({tag, "_wb_valid"}, bus.wb_valid, 0);
    check({tag, "_wb_is_vec"}, bus.wb_is_vec, 0);
    check({tag, "_wb_reg"}, bus.wb_reg, 0);
    check({tag, "_wb_data"}, bus.wb_data, 0);
    check({tag, "_illegal"}, bus.illegal_op, 0);
  endtask

  initial begin
    logic [127:0] last_data, exp_mul, v1_idx, rv1, rv2;
    logic [2:0]   last_reg, rwbr;
    logic         last_vec, rv, exp_wb, seen_wb;
    logic [4:0]   rop;
    logic [31:0]  rr1, rr2;
    logic [7:0]   rimm;
    int           cyc, r;

    n_checks = 0;
    n_errors = 0;

    tbl[0] = '{5'h00, 0, 0, 8'h00, splat(8'h12), splat(8'h34), 3'd1, 0, 0, 0, '0};
    tbl[1] = '{5'h01, 0, 0, 8'h00, splat(8'hF0), splat(8'h20), 3'd3, 1, 1, 0, splat(8'h10)};
    tbl[2] = '{5'h05, 32'hFFFF_FFFF, 32'd2, 8'h00, splat(8'hAA), splat(8'hBB), 3'd5, 1, 0, 0,
               128'h1};
    tbl[3] = '{5'h07, 0, 0, 8'h09, splat(8'h81), '0, 3'd6, 1, 1, 0, splat(8'h02)};
    tbl[4] = '{5'h1F, 0, 0, 8'h00, splat(8'h01), splat(8'h01), 3'd2, 0, 0, 1, '0};
    tbl[5] = '{5'h02, 0, 0, 8'h00, splat(8'h10), splat(8'h20), 3'd1, 1, 1, 0, splat(8'hF0)};
    tbl[6] = '{5'h03, 0, 0, 8'h00, splat(8'hAA), splat(8'h55), 3'd2, 1, 1, 0, splat(8'hFF)};
    tbl[7] = '{5'h04, 0, 0, 8'h03, splat(8'hFE), '0, 3'd7, 1, 1, 0, splat(8'h01)};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, '0, '0, 0);
    step();
    step();
    check_all_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table, applied back-to-back; held fields must persist through non-writebacks.
    last_data = '0;
    last_reg  = '0;
    last_vec  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1, tbl[i].op, tbl[i].r1, tbl[i].r2, tbl[i].imm, tbl[i].v1, tbl[i].v2, tbl[i].wbr);
      step();
      if (tbl[i].exp_valid) begin
        last_data = tbl[i].exp_data;
        last_reg  = tbl[i].wbr;
        last_vec  = tbl[i].exp_vec;
      end
      check($sformatf("tbl%0d_wb_valid", i), bus.wb_valid, tbl[i].exp_valid);
      check($sformatf("tbl%0d_wb_data", i), bus.wb_data, last_data);
      check($sformatf("tbl%0d_wb_reg", i), bus.wb_reg, last_reg);
      check($sformatf("tbl%0d_wb_is_vec", i), bus.wb_is_vec, last_vec);
      check($sformatf("tbl%0d_illegal", i), bus.illegal_op, tbl[i].exp_ill);
      check($sformatf("tbl%0d_stall", i), bus.stall, 0);
    end
    drive(0, 0, 0, 0, 0, '0, '0, 0);
    step();
    check("idle_wb_valid_drops", bus.wb_valid, 0);
    check("idle_illegal_drops", bus.illegal_op, 0);
    check("idle_wb_data_holds", bus.wb_data, splat(8'h01));

    // Asynchronous reset mid-cycle clears outputs without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // VMUL with a VADD held behind it.
    for (int i = 0; i < 16; i++) v1_idx[8*i +: 8] = 8'(i);
    exp_mul = ref_model(5'h06, 0, 0, 0, v1_idx, splat(8'h11));
    drive(1, 5'h06, 0, 0, 0, v1_idx, splat(8'h11), 3'd2);
    step();
    drive(1, 5'h01, 0, 0, 0, splat(8'h05), splat(8'h07), 3'd4);
    cyc = 0;
    while (bus.stall === 1'b1 && cyc < 10) begin
      check("vmul_no_early_wb", bus.wb_valid, 0);
      cyc++;
      step();
    end
    check("vmul_stall_cycles", 128'(cyc), 128'(4));
    check("vmul_wb_valid", bus.wb_valid, 1);
    check("vmul_wb_data", bus.wb_data, exp_mul);
    check("vmul_wb_reg", bus.wb_reg, 3'd2);
    check("vmul_wb_is_vec", bus.wb_is_vec, 1);
    step();
    check("held_vadd_wb_valid", bus.wb_valid, 1);
    check("held_vadd_wb_data", bus.wb_data, splat(8'h0C));
    check("held_vadd_wb_reg", bus.wb_reg, 3'd4);
    drive(0, 0, 0, 0, 0, '0, '0, 0);
    step();
    check("after_vadd_wb_valid", bus.wb_valid, 0);

    // Reset two cycles into VMUL aborts it.
    drive(1, 5'h06, 0, 0, 0, splat(8'h03), splat(8'h05), 3'd1);
    step();
    drive(0, 0, 0, 0, 0, '0, '0, 0);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_stall", bus.stall, 0);
    check("abort_wb_valid", bus.wb_valid, 0);
    check("abort_wb_data", bus.wb_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_wb = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.wb_valid === 1'b1 || bus.stall !== 1'b0) seen_wb = 1'b1;
    end
    check("abort_no_late_wb", seen_wb, 0);
    drive(1, 5'h01, 0, 0, 0, splat(8'h01), splat(8'h02), 3'd3);
    step();
    check("post_abort_vadd_valid", bus.wb_valid, 1);
    check("post_abort_vadd_data", bus.wb_data, splat(8'h03));
    last_data = splat(8'h03);
    last_reg  = 3'd3;
    last_vec  = 1'b1;

    // Randomized ops, with garbage on the bus while VMUL is busy.
    for (int t = 0; t < 300; t++) begin
      r    = int'($urandom_range(0, 9));
      rop  = (r <= 7) ? 5'(r) : 5'($urandom_range(8, 31));
      rv   = ($urandom_range(0, 3) != 0);
      rr1  = $urandom;
      rr2  = $urandom;
      rimm = 8'($urandom);
      rv1  = {$urandom, $urandom, $urandom, $urandom};
      rv2  = {$urandom, $urandom, $urandom, $urandom};
      rwbr = 3'($urandom);
      drive(rv, rop, rr1, rr2, rimm, rv1, rv2, rwbr);
      step();
      if (rv && rop == 5'h06) begin
        cyc = 0;
        while (bus.stall === 1'b1 && cyc < 10) begin
          drive(1'($urandom), 5'($urandom), $urandom, $urandom, 8'($urandom),
                {$urandom, $urandom, $urandom, $urandom},
                {$urandom, $urandom, $urandom, $urandom}, 3'($urandom));
          cyc++;
          step();
        end
        check($sformatf("rnd%0d_vmul_stall", t), 128'(cyc), 128'(4));
      end
      exp_wb = rv && (rop >= 5'h01) && (rop <= 5'h07);
      if (exp_wb) begin
        last_data = ref_model(rop, rr1, rr2, rimm, rv1, rv2);
        last_reg  = rwbr;
        last_vec  = (rop != 5'h05);
      end
      check($sformatf("rnd%0d_wb_valid op=%0h", t, rop), bus.wb_valid, exp_wb);
      check($sformatf("rnd%0d_wb_data op=%0h", t, rop), bus.wb_data, last_data);
      check($sformatf("rnd%0d_wb_reg", t), bus.wb_reg, last_reg);
      check($sformatf("rnd%0d_wb_is_vec", t), bus.wb_is_vec, last_vec);
      check($sformatf("rnd%0d_illegal op=%0h", t, rop), bus.illegal_op, rv && (rop >= 5'h08));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/vec_execute_unit.md
# vec_execute_unit

Execute stage of the vector CPU pipeline. It consumes the operands held in the decode/execute pipeline register: opcode, two scalar registers, the immediate, two 128-bit vectors and the writeback register index. It computes lane-wise 8-bit vector or 32-bit scalar results and presents a registered writeback beat to the writeback stage. The multi-cycle VMUL operation backpressures the decode/execute register through `stall`, which upstream inverts to form that register's `en`.

## Interface
Parameters:
- LANE_W, 8, lane width in bits (fixed; 16 lanes in 128 bits)
- MUL_LANES_PER_CYC, 4, VMUL lanes computed per cycle (must divide 16)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  operand set on the following inputs is valid
- opcode  in  5  operation code
- reg1_data, reg2_data  in  32 each  scalar operands
- immediate  in  8  immediate operand
- vec1_data, vec2_data  in  128 each  vector operands; lane i = bits [8i+7:8i]
- wb_register  in  3  destination register index
- stall  out  1  unit busy; upstream holds the decode/execute register while high
- wb_valid  out  1  one-cycle writeback pulse
- wb_is_vec  out  1  1 = vector destination, 0 = scalar
- wb_reg  out  3  destination index
- wb_data  out  128  result; scalar results in [31:0], [127:32] = 0
- illegal_op  out  1  one-cycle pulse on an undefined opcode

## Operation
- Opcodes, all lane-wise on 16 lanes with results mod 256:
  - 0x00 NOP: no writeback.
  - 0x01 VADD: v1 + v2.
  - 0x02 VSUB: v1 − v2.
  - 0x03 VXOR: v1 ^ v2.
  - 0x04 VADDI: v1 + immediate.
  - 0x05 SADD: reg1 + reg2 mod 2^32, scalar.
  - 0x06 VMUL: low 8 bits of v1 × v2, multi-cycle.
  - 0x07 VSHL: v1 << immediate[2:0] per lane, zero fill, no cross-lane carry.
  - 0x08–0x1F: illegal.
- Accept happens when in_valid=1 and state=IDLE, sampled at a rising edge.
- FSM states are IDLE and MUL.
  - IDLE + accept of VMUL: latch vec1/vec2/wb_register, clear the lane-group counter cnt (2 bits), go to MUL.
  - IDLE + accept of any other opcode: result is computed combinationally and registered at that same edge.
  - MUL: each edge computes lanes [4cnt .. 4cnt+3] into the result buffer and increments cnt. At the edge where cnt==3, the final group is written, wb_valid is set and the state returns to IDLE.
- Operands are latched internally at accept, so VMUL results do not depend on the input bus after acceptance.
- stall = (state==MUL), decoded combinationally from state.
- NOP, illegal opcodes and in_valid=0 produce no writeback. An illegal opcode pulses illegal_op for one cycle and the unit stays in IDLE.
- wb_is_vec = 0 only for SADD.

## Timing
- Reset values: state IDLE, cnt 0, stall 0, wb_valid 0, wb_is_vec 0, wb_reg 0, wb_data 0, illegal_op 0.
- Reset asserted mid-VMUL aborts immediately: no writeback, and partial results are discarded.
- Single-cycle ops accepted at edge N: wb_valid=1 during cycle N→N+1, and a back-to-back accept is possible at N+1.
- VMUL accepted at edge N:
  - stall is high from just after N to just after N+4 (4 cycles).
  - wb_valid is high during cycle N+4→N+5.
  - The next accept happens at edge N+5, so VMUL occupies 5 issue slots.
- An in_valid pulse while stall=1 is ignored. Upstream holding the register keeps the operand set stable until acceptance.
- wb_valid, wb_data, wb_reg, wb_is_vec and illegal_op are registered. In cycles without a writeback, wb_valid=0 and wb_data/wb_reg hold their last values.

## Test plan
- Reset with rst_n=0 mid-cycle, with no clock edge → all outputs 0 immediately. Then release reset, apply NOP with in_valid=1 → no wb_valid and no illegal_op.
- VADD with every v1 lane 0xF0 and every v2 lane 0x20, wb_register=3, at edge N → wb_data lanes all 0x10 (wrap), wb_reg=3, wb_is_vec=1, wb_valid high for exactly one cycle after N.
- SADD with reg1=0xFFFFFFFF, reg2=2, followed back-to-back by VSHL with lanes 0x81 and imm=1 → first beat wb_data=0x1 (scalar, upper bits 0, wb_is_vec=0). Next cycle, all lanes 0x02.
- VMUL with lane i of v1 = i and lane i of v2 = 0x11, then a VADD held behind it → stall high for exactly 4 cycles. wb_data lane i = (i×0x11) mod 256 one cycle after stall falls. VADD is accepted one edge later and its beat follows.
- Opcode 0x1F with in_valid=1 → illegal_op pulses once, no wb_valid, stall stays 0.
- Start VMUL, assert rst_n=0 after 2 MUL cycles, then release → no wb_valid ever appears, stall=0, and the next VADD completes normally.
